// File: rtl/keypad_if.sv
// Keypad scanner bundle: row drive and column sense in, decoded key out.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       pressed;

  modport master (output row, col, input key, key_valid, pressed);
  modport slave  (input row, col, output key, key_valid, pressed);
endinterface

// File: rtl/keypad_decoder.sv
// 4x4 matrix keypad decoder: synchronizes column sense, collects one hit per
// scan window and debounces press/release over whole scans.
module keypad_decoder #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic     clk,
  input  logic     rstn,
  keypad_if.slave  kp
);

  localparam int unsigned CW = 8;
  localparam int unsigned TW = CW + 1;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  state_t        state, state_n;
  logic [3:0]    col_s1, col_s2, row_d1, row_d2;
  logic          row_ok, cur_hit, win_end, any_hit, hit_seen;
  logic [1:0]    r_idx, c_idx;
  logic [3:0]    cur_code, hit_code;
  logic          win_hit_v, seen;
  logic [3:0]    win_hit;
  logic [3:0]    cand, cand_n, key_n;
  logic [CW-1:0] cnt, cnt_n, rcnt, rcnt_n;
  logic          key_valid_n, pressed_n, cnt_done, rcnt_done;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Two-flop column synchronizer with a matching two-stage row delay
  always_ff @(posedge clk) begin
    if (!rstn) begin
      col_s1 <= '0;
      col_s2 <= '0;
      row_d1 <= '0;
      row_d2 <= '0;
    end else begin
      col_s1 <= kp.col;
      col_s2 <= col_s1;
      row_d1 <= kp.row;
      row_d2 <= row_d1;
    end
  end

  always_comb begin
    row_ok = 1'b1;
    r_idx  = 2'd0;
    case (row_d2)
      4'b1000: r_idx = 2'd0;
      4'b0100: r_idx = 2'd1;
      4'b0010: r_idx = 2'd2;
      4'b0001: r_idx = 2'd3;
      default: row_ok = 1'b0;
    endcase
    if (col_s2[0])      c_idx = 2'd0;
    else if (col_s2[1]) c_idx = 2'd1;
    else if (col_s2[2]) c_idx = 2'd2;
    else                c_idx = 2'd3;
    cur_hit   = row_ok && (col_s2 != 4'b0000);
    cur_code  = {r_idx, c_idx};
    win_end   = (row_d2 == 4'b0001);
    // The window-end cycle itself belongs to the window being closed
    any_hit   = win_hit_v | cur_hit;
    hit_code  = win_hit_v ? win_hit : cur_code;
    hit_seen  = seen | (cur_hit && (cur_code == cand));
    cnt_done  = ({1'b0, cnt}  + TW'(1)) >= TW'(DEBOUNCE_SCANS);
    rcnt_done = ({1'b0, rcnt} + TW'(1)) >= TW'(DEBOUNCE_SCANS);
  end

  // First hit of the window and whether the candidate appeared at all
  always_ff @(posedge clk) begin
    if (!rstn) begin
      win_hit_v <= 1'b0;
      win_hit   <= '0;
      seen      <= 1'b0;
    end else if (win_end) begin
      win_hit_v <= 1'b0;
      win_hit   <= '0;
      seen      <= 1'b0;
    end else begin
      if (cur_hit && !win_hit_v) begin
        win_hit_v <= 1'b1;
        win_hit   <= cur_code;
      end
      if (cur_hit && (cur_code == cand)) seen <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cand_n      = cand;
    cnt_n       = cnt;
    rcnt_n      = rcnt;
    key_n       = kp.key;
    key_valid_n = 1'b0;
    if (win_end) begin
      case (state)
        IDLE: begin
          if (any_hit) begin
            cand_n  = hit_code;
            cnt_n   = CW'(1);
            state_n = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (hit_seen) begin
            cnt_n = sat_inc(cnt);
            if (cnt_done) begin
              key_n       = cand;
              key_valid_n = 1'b1;
              rcnt_n      = '0;
              state_n     = HELD;
            end
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        HELD: begin
          if (hit_seen) begin
            rcnt_n = '0;
          end else begin
            rcnt_n = sat_inc(rcnt);
            if (rcnt_done) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    pressed_n = (state_n == HELD);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cand         <= '0;
      cnt          <= '0;
      rcnt         <= '0;
      kp.key       <= '0;
      kp.key_valid <= 1'b0;
      kp.pressed   <= 1'b0;
    end else begin
      cand         <= cand_n;
      cnt          <= cnt_n;
      rcnt         <= rcnt_n;
      kp.key       <= key_n;
      kp.key_valid <= key_valid_n;
      kp.pressed   <= pressed_n;
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder: hand-derived per-window table plus
// randomized scans against a window-level behavioural model.
module tb_keypad_decoder;

  localparam int NSCAN = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  keypad_if kif();

  keypad_decoder #(.DEBOUNCE_SCANS(NSCAN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .kp   (kif.slave)
  );

  typedef struct {
    logic [15:0] mask;
    int          reps;
    bit          bad;
    bit          exp_valid;
    logic [3:0]  exp_key;
    bit          exp_pressed;
  } vec_t;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } smp_t;

  vec_t tbl[$];
  smp_t hist[$];
  int   win_hits[$];

  int         n_vec = 0;
  int         n_err = 0;
  int         n_pulse = 0;
  int         m_state, m_cnt, m_rcnt;
  logic [3:0] m_cand, m_key;
  bit         m_valid;
  bit         pend, prev_valid;
  vec_t       pend_v;
  int         ph;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    smp_t z;
    z = '0;
    m_state = 0; m_cnt = 0; m_rcnt = 0;
    m_cand = '0; m_key = '0; m_valid = 1'b0;
    win_hits.delete();
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
  endfunction

  // Model: state 0=idle, 1=debounce, 2=held; decisions only at window end
  function automatic void m_step(input smp_t s);
    int  r, c;
    bit  seen;
    m_valid = 1'b0;
    if ($countones(s.row) == 1 && s.col != 4'b0000) begin
      r = 0; c = 0;
      for (int i = 0; i < 4; i++) if (s.row[3-i]) r = i;
      for (int i = 3; i >= 0; i--) if (s.col[i]) c = i;
      win_hits.push_back(r * 4 + c);
    end
    if (s.row == 4'b0001) begin
      seen = 1'b0;
      foreach (win_hits[i]) if (win_hits[i] == int'(m_cand)) seen = 1'b1;
      case (m_state)
        0: if (win_hits.size() > 0) begin
             m_cand = 4'(win_hits[0]); m_cnt = 1; m_state = 1;
           end
        1: if (seen) begin
             if (m_cnt + 1 >= NSCAN) begin
               m_key = m_cand; m_valid = 1'b1; m_rcnt = 0; m_state = 2;
             end
             m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
           end else begin
             m_cnt = 0; m_state = 0;
           end
        default: if (seen) m_rcnt = 0;
           else begin
             if (m_rcnt + 1 >= NSCAN) m_state = 0;
             m_rcnt = (m_rcnt + 1 > 255) ? 255 : m_rcnt + 1;
           end
      endcase
      win_hits.delete();
    end
  endfunction

  task automatic cycle(input logic [3:0] r, input logic [3:0] c);
    smp_t s;
    kif.row = r;
    kif.col = c;
    s.row = r;
    s.col = c;
    hist.push_back(s);
    @(posedge clk);
    m_step(hist.pop_front());
    #1;
    chk("key", int'(kif.key), int'(m_key));
    chk("key_valid", int'(kif.key_valid), int'(m_valid));
    chk("pressed", int'(kif.pressed), int'(m_state == 2));
    chk("valid_back_to_back", int'(prev_valid & kif.key_valid), 0);
    prev_valid = kif.key_valid;
    if (kif.key_valid) n_pulse++;
    // Window results of the previous scan become visible on phase 1
    if (ph == 1 && pend) begin
      chk("tbl_key", int'(kif.key), int'(pend_v.exp_key));
      chk("tbl_valid", int'(kif.key_valid), int'(pend_v.exp_valid));
      chk("tbl_pressed", int'(kif.pressed), int'(pend_v.exp_pressed));
      pend = 1'b0;
    end
  endtask

  task automatic scan(input logic [15:0] mask, input bit bad);
    for (int p = 0; p < 4; p++) begin
      ph = p;
      if (bad && p < 3) cycle(4'b1100, 4'b1111);
      else              cycle(4'(8 >> p), mask[p*4 +: 4]);
    end
  endtask

  task automatic do_reset(input int ncyc);
    rstn    = 1'b0;
    kif.row = '0;
    kif.col = '0;
    repeat (ncyc) @(posedge clk);
    m_reset();
    #1;
    rstn = 1'b1;
    chk("rst_key", int'(kif.key), 0);
    chk("rst_valid", int'(kif.key_valid), 0);
    chk("rst_pressed", int'(kif.pressed), 0);
    prev_valid = 1'b0;
    pend       = 1'b0;
  endtask

  function automatic void add(input logic [15:0] m, input int reps, input bit bad,
                              input bit v, input logic [3:0] k, input bit p);
    vec_t e;
    e.mask = m; e.reps = reps; e.bad = bad;
    e.exp_valid = v; e.exp_key = k; e.exp_pressed = p;
    tbl.push_back(e);
  endfunction

  localparam logic [15:0] M3  = 16'h0008;
  localparam logic [15:0] M5  = 16'h0020;
  localparam logic [15:0] M6  = 16'h0040;
  localparam logic [15:0] M8  = 16'h0100;
  localparam logic [15:0] M13 = 16'h2000;

  initial begin
    logic [15:0] rmask;
    int          p0;
    vec_t        e;

    add(16'h0,     20, 0, 0, 4'd0,  0);
    add(M6,         3, 0, 0, 4'd0,  0);
    add(M6,         1, 0, 1, 4'd6,  1);
    add(M6,         2, 0, 0, 4'd6,  1);
    add(16'h0,      3, 0, 0, 4'd6,  1);
    add(16'h0,      1, 0, 0, 4'd6,  0);
    add(M8,         2, 0, 0, 4'd6,  0);
    add(16'h0,      1, 0, 0, 4'd6,  0);
    add(M8,         3, 0, 0, 4'd6,  0);
    add(M8,         1, 0, 1, 4'd8,  1);
    add(M8,         1, 0, 0, 4'd8,  1);
    add(16'h0,      3, 0, 0, 4'd8,  1);
    add(16'h0,      1, 0, 0, 4'd8,  0);
    add(M3,         3, 0, 0, 4'd8,  0);
    add(M3,         1, 0, 1, 4'd3,  1);
    add(M3 | M13,   2, 0, 0, 4'd3,  1);
    add(M13,        3, 0, 0, 4'd3,  1);
    add(M13,        1, 0, 0, 4'd3,  0);
    add(M13,        3, 0, 0, 4'd3,  0);
    add(M13,        1, 0, 1, 4'd13, 1);
    add(16'h0,      3, 0, 0, 4'd13, 1);
    add(16'h0,      1, 0, 0, 4'd13, 0);
    add(16'h0,      5, 1, 0, 4'd13, 0);

    kif.row = '0;
    kif.col = '0;
    ph = 0;
    do_reset(2);

    foreach (tbl[i]) begin
      e = tbl[i];
      for (int k = 0; k < e.reps; k++) begin
        scan(e.mask, e.bad);
        pend   = 1'b1;
        pend_v = e;
      end
    end
    scan(16'h0, 1'b0);

    // Reset while debouncing with three stable windows already counted
    for (int k = 0; k < 3; k++) scan(M5, 1'b0);
    ph = 0; cycle(4'b1000, 4'b0000);
    ph = 1; cycle(4'b0100, 4'b0010);
    chk("pre_reset_pressed", int'(kif.pressed), 0);
    p0 = n_pulse;
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      scan(M5, 1'b0);
      pend   = 1'b1;
      pend_v = '{mask: M5, reps: 1, bad: 1'b0, exp_valid: (k == 3),
                 exp_key: (k == 3) ? 4'd5 : 4'd0, exp_pressed: (k == 3)};
    end
    scan(16'h0, 1'b0);
    chk("reset_abort_pulses", n_pulse - p0, 1);

    // Randomized sticky key patterns with occasional bad rows and resets
    rmask = '0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 59) == 0) do_reset(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 99) < 15) begin
        case ($urandom_range(0, 3))
          0:       rmask = '0;
          3:       rmask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
          default: rmask = 16'h1 << $urandom_range(0, 15);
        endcase
      end
      scan(rmask, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_decoder.md
KEYPAD_DECODER -- requirements
Module: keypad_decoder

Interface
REQ-001 Parameter: DEBOUNCE_SCANS, default 4, number of consecutive full scans a key must be stable (legal range 1..255).
REQ-002 clk  input  1  system clock.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 row  input  4  one-hot row drive from the row scanner; rotates 1000->0100->0010->0001->1000, one step per clk.
REQ-005 col  input  4  raw asynchronous column sense, active-high; col[c]=1 means a key at (driven row, c) is closed.
REQ-006 key  output  4  code of the last accepted key, {r[1:0], c[1:0]}.
REQ-007 key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-008 pressed  output  1  level, high while the accepted key is held.

Function
REQ-009 col SHALL pass through a two-flop synchronizer; row SHALL be delayed by two registers so that delayed row and synchronized col are cycle-aligned.
REQ-010 Row index r: delayed row 1000->0, 0100->1, 0010->2, 0001->3; a delayed row that is not one-hot SHALL be ignored (no hit that cycle).
REQ-011 Column index c: the lowest set bit of synchronized col; col=0000 means no hit.
REQ-012 A scan window is four consecutive cycles and SHALL end on the cycle the delayed row equals 0001.
REQ-013 Within a window, the first hit in row order SHALL be captured as the window hit; later hits in the same window SHALL be ignored.
REQ-014 The block SHALL also record whether the current candidate code was hit anywhere in the window ("seen"); the window hit and "seen" SHALL be cleared after each window end.
REQ-015 States SHALL be IDLE, DEBOUNCE and HELD; all transitions SHALL occur only at window end.
REQ-016 IDLE: if a window hit exists, latch candidate <= hit, set cnt <= 1 and go to DEBOUNCE; else stay in IDLE.
REQ-017 DEBOUNCE, candidate seen:
  - increment cnt;
  - if cnt+1 >= DEBOUNCE_SCANS: set key <= candidate, pulse key_valid for exactly one cycle, go to HELD, clear rcnt.
REQ-018 DEBOUNCE, candidate not seen: go to IDLE and clear cnt.
REQ-019 DEBOUNCE_SCANS=1: the IDLE->DEBOUNCE transition is followed by acceptance at the next window end if the candidate is seen again.
REQ-020 HELD, candidate seen: rcnt <= 0.
REQ-021 HELD, candidate not seen: increment rcnt; when rcnt+1 >= DEBOUNCE_SCANS, go to IDLE.
REQ-022 pressed SHALL be high exactly while in HELD.
REQ-023 In HELD, hits on other keys SHALL be ignored; after the held key releases to IDLE, a still-held other key SHALL be detected as a new press.
REQ-024 key SHALL hold its value until the next acceptance; key_valid SHALL never assert in two consecutive cycles.
REQ-025 cnt and rcnt SHALL be 8 bits and SHALL saturate, never wrap.

Reset
REQ-026 With rstn=0 at a clk edge, the block SHALL clear:
  - state to IDLE;
  - key, key_valid, pressed, cnt, rcnt to 0;
  - synchronizer flops, row delay registers, window hit, seen and candidate.
REQ-027 Reset mid-operation (DEBOUNCE or HELD) SHALL abort with no key_valid pulse; after release the decode SHALL restart from IDLE with a fresh window.

Verification
REQ-028 Reset then col=0000 for 20 scans -> key=0, key_valid never high, pressed=0.
REQ-029 DEBOUNCE_SCANS=4; key (r=1,c=2) held stable for 6 scans -> a single key_valid pulse with key=4'b0110 at the end of the 4th hit window; pressed=1 from then on.
REQ-030 Key (2,0) seen in 2 windows, absent in 1, then seen in 4 -> no pulse on the first burst; exactly one pulse with key=4'b1000 after the fourth stable window.
REQ-031 Hold (0,3) until accepted, then add (3,1) and release (0,3):
  - pressed drops after 4 absent windows;
  - a new pulse with key=4'b1101 follows 4 windows later.
REQ-032 rstn=0 for 1 cycle while in DEBOUNCE with cnt=3 -> no pulse; outputs 0; the same key is accepted 4 full windows after reset release.
REQ-033 Non-one-hot row (e.g. 1100 injected) with col=1111 -> no hit recorded for those cycles.
